// File: rtl/timer_ctrl_pkg.sv
// Shared types for the adv-timer channel command sequencer.
// Holds the sequencer state enum and the state codes exported on state_o.
package timer_ctrl_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_LOAD = 2'd1;
    localparam logic [1:0] ENC_RUN  = 2'd2;
    localparam logic [1:0] ENC_PEND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_LOAD = ENC_LOAD,
        ST_RUN  = ENC_RUN,
        ST_PEND = ENC_PEND
    } timer_ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk_i, rst_i (async, active-high), clr_i, inc_i, cnt_o[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Command sequencer for one adv-timer channel: turns register-write command
// pulses into registered active/update/arm/clear controls for the datapath.
// Ports:
//   clk_i, rst_i (async, active-high)
//   cmd_start_i, cmd_stop_i, cmd_update_i, cmd_reset_i, cmd_arm_i : pulses
//   cfg_oneshot_i, cfg_upd_sync_i : channel config
//   cnt_end_i : counter period-end strobe
//   ctrl_active_o, ctrl_update_o, ctrl_arm_o, ctrl_rst_o, end_o : controls
//   state_o : sequencer state, evt_cnt_o : saturating completed periods
module timer_ctrl_fsm
    import timer_ctrl_pkg::*;
#(
    parameter logic ONESHOT_DEF = 1'b0,
    parameter int   EVT_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_start_i,
    input  logic                 cmd_stop_i,
    input  logic                 cmd_update_i,
    input  logic                 cmd_reset_i,
    input  logic                 cmd_arm_i,
    input  logic                 cfg_oneshot_i,
    input  logic                 cfg_upd_sync_i,
    input  logic                 cnt_end_i,
    output logic                 ctrl_active_o,
    output logic                 ctrl_update_o,
    output logic                 ctrl_arm_o,
    output logic                 ctrl_rst_o,
    output logic                 end_o,
    output logic [1:0]           state_o,
    output logic [EVT_CNT_W-1:0] evt_cnt_o
);

    timer_ctrl_state_e state_q, state_d;
    logic oneshot_q, oneshot_d;
    logic active_q, active_d;
    logic upd_q, upd_d;
    logic rst_q, rst_d;
    logic arm_q, arm_d;
    logic end_q, end_d;
    logic cnt_clr;
    logic counting;
    logic req_pend;

    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        upd_d     = 1'b0;
        rst_d     = cmd_reset_i;
        arm_d     = cmd_arm_i;
        cnt_clr   = cmd_reset_i;
        req_pend  = 1'b0;
        counting  = (state_q == ST_RUN) || (state_q == ST_PEND);
        // Period ends only count while the channel is enabled.
        end_d     = counting && cnt_end_i;

        unique case (state_q)
            ST_IDLE: begin
                if (!cmd_stop_i) begin
                    if (cmd_start_i) begin
                        // Load config and clear counter before enabling.
                        state_d   = ST_LOAD;
                        oneshot_d = cfg_oneshot_i;
                        upd_d     = 1'b1;
                        rst_d     = 1'b1;
                        cnt_clr   = 1'b1;
                    end else if (cmd_update_i) begin
                        upd_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = cmd_stop_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (cmd_stop_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cmd_update_i) begin
                        if (cfg_upd_sync_i) begin
                            req_pend = 1'b1;
                        end else begin
                            upd_d = 1'b1;
                        end
                    end
                    // One-shot termination wins over a deferral request.
                    if (cnt_end_i && oneshot_q) begin
                        state_d = ST_IDLE;
                    end else if (req_pend) begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (cmd_stop_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_end_i) begin
                    upd_d   = 1'b1;
                    state_d = oneshot_q ? ST_IDLE : ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d = (state_d == ST_RUN) || (state_d == ST_PEND);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            oneshot_q <= ONESHOT_DEF;
            active_q  <= 1'b0;
            upd_q     <= 1'b0;
            rst_q     <= 1'b0;
            arm_q     <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            oneshot_q <= oneshot_d;
            active_q  <= active_d;
            upd_q     <= upd_d;
            rst_q     <= rst_d;
            arm_q     <= arm_d;
            end_q     <= end_d;
        end
    end

    sat_counter #(
        .W(EVT_CNT_W)
    ) u_evt_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (end_d),
        .cnt_o (evt_cnt_o)
    );

    assign ctrl_active_o = active_q;
    assign ctrl_update_o = upd_q;
    assign ctrl_rst_o    = rst_q;
    assign ctrl_arm_o    = arm_q;
    assign end_o         = end_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Self-checking bench for timer_ctrl_fsm: vector table, corner sequences,
// and randomized commands against a flag-based reference model.
module tb_timer_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cmd_start_i, cmd_stop_i, cmd_update_i, cmd_reset_i, cmd_arm_i;
    logic       cfg_oneshot_i, cfg_upd_sync_i, cnt_end_i;
    logic       ctrl_active_o, ctrl_update_o, ctrl_arm_o, ctrl_rst_o, end_o;
    logic [1:0] state_o;
    logic [7:0] evt_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_ctrl_fsm #(
        .ONESHOT_DEF(1'b0),
        .EVT_CNT_W  (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cmd_start_i   (cmd_start_i),
        .cmd_stop_i    (cmd_stop_i),
        .cmd_update_i  (cmd_update_i),
        .cmd_reset_i   (cmd_reset_i),
        .cmd_arm_i     (cmd_arm_i),
        .cfg_oneshot_i (cfg_oneshot_i),
        .cfg_upd_sync_i(cfg_upd_sync_i),
        .cnt_end_i     (cnt_end_i),
        .ctrl_active_o (ctrl_active_o),
        .ctrl_update_o (ctrl_update_o),
        .ctrl_arm_o    (ctrl_arm_o),
        .ctrl_rst_o    (ctrl_rst_o),
        .end_o         (end_o),
        .state_o       (state_o),
        .evt_cnt_o     (evt_cnt_o)
    );

    // {state, active, update, rst, arm, end, evt_cnt}
    function automatic logic [14:0] obs();
        return {state_o, ctrl_active_o, ctrl_update_o, ctrl_rst_o,
                ctrl_arm_o, end_o, evt_cnt_o};
    endfunction

    task automatic check(input string name, input logic [14:0] got,
                         input logic [14:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: channel enabled / loading / update pending flags.
    bit          m_on, m_load, m_pend, m_os;
    int          m_cnt;
    logic [14:0] m_exp;
    localparam int CMAX = 255;

    task automatic model_reset();
        m_on = 0; m_load = 0; m_pend = 0; m_os = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit rs, sp, st, up, ar, os, sy, ce);
        bit e_upd = 0;
        bit e_end = 0;
        bit e_rst = rs;
        bit clr = rs;
        bit want = 0;
        logic [1:0] es;
        if (m_load) begin
            m_load = 0;
            if (!sp) m_on = 1;
        end else if (!m_on) begin
            if (!sp && st) begin
                m_load = 1; m_os = os; clr = 1; e_upd = 1; e_rst = 1;
            end else if (!sp && up) begin
                e_upd = 1;
            end
        end else begin
            if (ce) e_end = 1;
            if (sp) begin
                m_on = 0; m_pend = 0;
            end else if (m_pend) begin
                if (ce) begin
                    e_upd = 1; m_pend = 0;
                    if (m_os) m_on = 0;
                end
            end else begin
                if (up) begin
                    if (sy) want = 1;
                    else e_upd = 1;
                end
                if (ce && m_os) m_on = 0;
                else if (want) m_pend = 1;
            end
        end
        if (clr) m_cnt = 0;
        else if (e_end) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        es = m_load ? 2'd1 : (!m_on ? 2'd0 : (m_pend ? 2'd3 : 2'd2));
        m_exp = {es, m_on, e_upd, e_rst, ar, e_end, 8'(m_cnt)};
    endtask

    task automatic drive(input bit rs, sp, st, up, ar, os, sy, ce);
        cmd_reset_i    = rs;
        cmd_stop_i     = sp;
        cmd_start_i    = st;
        cmd_update_i   = up;
        cmd_arm_i      = ar;
        cfg_oneshot_i  = os;
        cfg_upd_sync_i = sy;
        cnt_end_i      = ce;
        model_step(rs, sp, st, up, ar, os, sy, ce);
        @(posedge clk);
        #1;
        check("model", obs(), m_exp);
    endtask

    typedef struct {
        logic [4:0]  cmd;   // {reset, stop, start, update, arm}
        logic        os;
        logic        sy;
        logic        ce;
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] cmd, input logic os, sy, ce,
                                input logic [1:0] s, input logic act, upd,
                                input logic rs, ar, en, input logic [7:0] c);
        vec_t v;
        v.cmd = cmd; v.os = os; v.sy = sy; v.ce = ce;
        v.exp = {s, act, upd, rs, ar, en, c};
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        int ends;
        int upds;

        vecs[0]  = mk(5'b00000, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 8'd0);
        vecs[1]  = mk(5'b00100, 0, 0, 0, 2'd1, 0, 1, 1, 0, 0, 8'd0);
        vecs[2]  = mk(5'b00000, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 8'd0);
        vecs[3]  = mk(5'b00000, 0, 0, 1, 2'd2, 1, 0, 0, 0, 1, 8'd1);
        vecs[4]  = mk(5'b00010, 0, 0, 0, 2'd2, 1, 1, 0, 0, 0, 8'd1);
        vecs[5]  = mk(5'b00010, 0, 1, 0, 2'd3, 1, 0, 0, 0, 0, 8'd1);
        vecs[6]  = mk(5'b00010, 0, 1, 0, 2'd3, 1, 0, 0, 0, 0, 8'd1);
        vecs[7]  = mk(5'b00000, 0, 0, 1, 2'd2, 1, 1, 0, 0, 1, 8'd2);
        vecs[8]  = mk(5'b00001, 0, 0, 0, 2'd2, 1, 0, 0, 1, 0, 8'd2);
        vecs[9]  = mk(5'b11101, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0, 8'd0);
        vecs[10] = mk(5'b00010, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 8'd0);
        vecs[11] = mk(5'b00000, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0, 8'd0);
        vecs[12] = mk(5'b00100, 1, 0, 0, 2'd1, 0, 1, 1, 0, 0, 8'd0);
        vecs[13] = mk(5'b00000, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 8'd0);
        vecs[14] = mk(5'b00000, 0, 0, 1, 2'd0, 0, 0, 0, 0, 1, 8'd1);
        vecs[15] = mk(5'b00100, 0, 0, 0, 2'd1, 0, 1, 1, 0, 0, 8'd0);
        vecs[16] = mk(5'b01000, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 8'd0);
        vecs[17] = mk(5'b00100, 0, 0, 0, 2'd1, 0, 1, 1, 0, 0, 8'd0);
        vecs[18] = mk(5'b00000, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 8'd0);
        vecs[19] = mk(5'b00000, 0, 0, 1, 2'd2, 1, 0, 0, 0, 1, 8'd1);
        vecs[20] = mk(5'b10000, 0, 0, 1, 2'd2, 1, 0, 1, 0, 1, 8'd0);
        vecs[21] = mk(5'b00100, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 8'd0);

        rst_i = 1'b1;
        cmd_start_i = 0; cmd_stop_i = 0; cmd_update_i = 0;
        cmd_reset_i = 0; cmd_arm_i = 0;
        cfg_oneshot_i = 0; cfg_upd_sync_i = 0; cnt_end_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 15'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].cmd[4], vecs[i].cmd[3], vecs[i].cmd[2],
                  vecs[i].cmd[1], vecs[i].cmd[0],
                  vecs[i].os, vecs[i].sy, vecs[i].ce);
            check($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Deferred update: request at t0, period end at t0+10.
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        check1("pend_state", int'(state_o), 3);
        upds = 0;
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            upds += int'(ctrl_update_o);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        upds += int'(ctrl_update_o);
        check1("pend_upd_at_end", int'(ctrl_update_o), 1);
        check1("pend_back_run", int'(state_o), 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        upds += int'(ctrl_update_o);
        check1("pend_single_upd", upds, 1);

        // Saturation of the period counter.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        ends = 0;
        for (int k = 0; k < 300; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            ends += int'(end_o);
        end
        check1("sat_ends", ends, 300);
        check1("sat_cnt", int'(evt_cnt_o), 255);

        // Async reset while an update is pending.
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        check1("pre_rst_pend", int'(state_o), 3);
        #3;
        rst_i = 1'b1;
        #1;
        check("async_rst", obs(), 15'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        check1("rst_no_upd", int'(ctrl_update_o), 0);

        // Randomized commands against the model.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 19) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
